// File: rtl/saturn_pc_rstk_ng_if.sv
// saturn_pc_rstk_ng_if
// Command/status bundle between the instruction decoder (master) and the
// PC/return-stack unit (slave).
//   i_clk_en, i_stall           : enabled cycle = i_clk_en && !i_stall
//   i_inc_pc                    : PC += 1
//   i_jump_start, i_jump_len,
//   i_jump_rel, i_push_pc       : start a jump / GOSUB decode
//   i_nibble_valid, i_nibble    : offset nibbles, least significant first
//   i_rtn, i_pop, i_push_val,
//   i_push_data                 : return-stack commands
//   i_dbg_idx / o_dbg_val       : combinational stack slot peek
//   o_pc, o_pop_data, o_busy, o_jump_done,
//   o_rstk_depth, o_rstk_ovf, o_rstk_unf : status
interface saturn_pc_rstk_ng_if #(
    parameter int ADDR_W = 20,
    parameter int DEPTH  = 8
);
    localparam int PW = $clog2(DEPTH);

    logic              i_clk_en;
    logic              i_stall;
    logic              i_inc_pc;
    logic              i_jump_start;
    logic [2:0]        i_jump_len;
    logic              i_jump_rel;
    logic              i_push_pc;
    logic              i_nibble_valid;
    logic [3:0]        i_nibble;
    logic              i_rtn;
    logic              i_push_val;
    logic [ADDR_W-1:0] i_push_data;
    logic              i_pop;
    logic [PW-1:0]     i_dbg_idx;

    logic [ADDR_W-1:0] o_pc;
    logic [ADDR_W-1:0] o_pop_data;
    logic              o_busy;
    logic              o_jump_done;
    logic [PW:0]       o_rstk_depth;
    logic              o_rstk_ovf;
    logic              o_rstk_unf;
    logic [ADDR_W-1:0] o_dbg_val;

    modport master (
        output i_clk_en, i_stall, i_inc_pc, i_jump_start, i_jump_len,
               i_jump_rel, i_push_pc, i_nibble_valid, i_nibble, i_rtn,
               i_push_val, i_push_data, i_pop, i_dbg_idx,
        input  o_pc, o_pop_data, o_busy, o_jump_done, o_rstk_depth,
               o_rstk_ovf, o_rstk_unf, o_dbg_val
    );

    modport slave (
        input  i_clk_en, i_stall, i_inc_pc, i_jump_start, i_jump_len,
               i_jump_rel, i_push_pc, i_nibble_valid, i_nibble, i_rtn,
               i_push_val, i_push_data, i_pop, i_dbg_idx,
        output o_pc, o_pop_data, o_busy, o_jump_done, o_rstk_depth,
               o_rstk_ovf, o_rstk_unf, o_dbg_val
    );
endinterface

// File: rtl/saturn_pc_rstk_ng.sv
// saturn_pc_rstk_ng
// Program counter and return stack for the Saturn core. Decodes 1..MAX_NIB
// nibble relative/absolute jump offsets, GOSUB push, RTN pop and the
// RSTK=C / C=RSTK transfers.
// Ports:
//   i_clk   : clock, rising edge
//   i_reset : synchronous active-high reset (restarts stack clearing)
//   bus     : saturn_pc_rstk_ng_if.slave command/status bundle
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_INIT | clear one stack slot per clock; all commands ignored
// ST_IDLE | accept one command per enabled cycle (rtn > pop > push > jump)
// ST_JUMP | collect offset nibbles; load PC on the last one
module saturn_pc_rstk_ng #(
    parameter int ADDR_W     = 20,
    parameter int DEPTH      = 8,
    parameter int MAX_NIB    = 5,
    parameter int STACK_MODE = 1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    saturn_pc_rstk_ng_if.slave   bus
);
    localparam int PW    = $clog2(DEPTH);
    localparam int OFF_W = MAX_NIB * 4;
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_JUMP} state_t;

    state_t            state_q, state_d;
    logic [PW:0]       init_cnt_q;
    logic [ADDR_W-1:0] pc_q, pop_data_q, ret_q, base_q;
    logic [2:0]        len_q, nib_cnt_q;
    logic              rel_q, push_q;
    logic [OFF_W-1:0]  offset_q, offset_nx;
    logic [PW-1:0]     ptr_q, ptr_inc;
    logic [PW:0]       depth_q;
    logic              ovf_q, unf_q, jump_done_q;
    logic [ADDR_W-1:0] rstk_q [DEPTH];

    logic              en, empty;
    logic              init_clr, do_push, do_pop, pop_to_pc, start_jump;
    logic              nib_wr, jump_fin;
    logic [ADDR_W-1:0] push_value, pop_value, ret_calc, off_ext, target;
    logic              sign_bit;

    assign en       = bus.i_clk_en && !bus.i_stall;
    assign empty    = (depth_q == '0);
    assign ptr_inc  = ptr_q + PW'(1);
    assign ret_calc = pc_q + ADDR_W'(bus.i_jump_len) + ADDR_W'(1);
    // Saturating mode hides the stale slot on underflow; legacy mode exposes it.
    assign pop_value = (empty && STACK_MODE == 1) ? '0 : rstk_q[ptr_q];

    always_ff @(posedge i_clk) begin
        if (i_reset) state_q <= ST_INIT;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        init_clr   = 1'b0;
        do_push    = 1'b0;
        do_pop     = 1'b0;
        pop_to_pc  = 1'b0;
        start_jump = 1'b0;
        nib_wr     = 1'b0;
        jump_fin   = 1'b0;
        push_value = '0;
        case (state_q)
            ST_INIT: begin
                if (init_cnt_q == DEPTH_C) state_d = ST_IDLE;
                else                       init_clr = 1'b1;
            end
            ST_IDLE: begin
                if (en) begin
                    if (bus.i_rtn) begin
                        do_pop    = 1'b1;
                        pop_to_pc = 1'b1;
                    end else if (bus.i_pop) begin
                        do_pop = 1'b1;
                    end else if (bus.i_push_val) begin
                        do_push    = 1'b1;
                        push_value = bus.i_push_data;
                    end else if (bus.i_jump_start) begin
                        start_jump = 1'b1;
                        state_d    = ST_JUMP;
                    end
                end
            end
            ST_JUMP: begin
                if (en && bus.i_nibble_valid) begin
                    nib_wr = 1'b1;
                    if (nib_cnt_q == len_q) begin
                        jump_fin = 1'b1;
                        state_d  = ST_IDLE;
                        if (push_q) begin
                            do_push    = 1'b1;
                            push_value = ret_q;
                        end
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // Offset including the nibble arriving this cycle, so the last nibble
    // feeds the target directly instead of costing an extra clock.
    always_comb begin
        offset_nx = offset_q;
        for (int j = 0; j < MAX_NIB; j++) begin
            if (int'(nib_cnt_q) == j) offset_nx[4*j +: 4] = bus.i_nibble;
        end
    end

    always_comb begin
        sign_bit = 1'b0;
        for (int j = 0; j < MAX_NIB; j++) begin
            if (int'(len_q) == j) sign_bit = offset_nx[4*j+3];
        end
        off_ext = '0;
        for (int i = 0; i < OFF_W; i++) begin
            if ((i / 4) <= int'(len_q)) off_ext[i] = offset_nx[i];
            else                        off_ext[i] = rel_q & sign_bit;
        end
        for (int i = OFF_W; i < ADDR_W; i++) begin
            off_ext[i] = rel_q & sign_bit;
        end
        target = (rel_q ? base_q : '0) + off_ext;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            init_cnt_q  <= '0;
            pc_q        <= '0;
            pop_data_q  <= '0;
            ret_q       <= '0;
            base_q      <= '0;
            len_q       <= '0;
            nib_cnt_q   <= '0;
            rel_q       <= 1'b0;
            push_q      <= 1'b0;
            offset_q    <= '0;
            ptr_q       <= PW'(DEPTH - 1);
            depth_q     <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            jump_done_q <= 1'b0;
        end else begin
            jump_done_q <= jump_fin;
            if (init_clr) init_cnt_q <= init_cnt_q + (PW+1)'(1);

            if (start_jump) begin
                len_q     <= bus.i_jump_len;
                rel_q     <= bus.i_jump_rel;
                push_q    <= bus.i_push_pc;
                ret_q     <= ret_calc;
                base_q    <= bus.i_push_pc ? ret_calc : pc_q;
                offset_q  <= '0;
                nib_cnt_q <= '0;
            end
            if (nib_wr) begin
                offset_q  <= offset_nx;
                nib_cnt_q <= nib_cnt_q + 3'd1;
            end

            if (jump_fin)
                pc_q <= target;
            else if (pop_to_pc)
                pc_q <= pop_value;
            else if (en && bus.i_inc_pc && state_q != ST_INIT)
                pc_q <= pc_q + ADDR_W'(1);

            if (do_pop && !pop_to_pc) pop_data_q <= pop_value;

            if (do_push) begin
                ptr_q <= ptr_inc;
                if (depth_q == DEPTH_C) ovf_q   <= 1'b1;
                else                    depth_q <= depth_q + (PW+1)'(1);
            end else if (do_pop) begin
                if (empty) begin
                    unf_q <= 1'b1;
                    if (STACK_MODE == 0) ptr_q <= ptr_q - PW'(1);
                end else begin
                    ptr_q   <= ptr_q - PW'(1);
                    depth_q <= depth_q - (PW+1)'(1);
                end
            end
        end
    end

    // Stack storage has no reset of its own; INIT clears it slot by slot.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            if (init_clr)     rstk_q[init_cnt_q[PW-1:0]] <= '0;
            else if (do_push) rstk_q[ptr_inc]            <= push_value;
            else if (do_pop)  rstk_q[ptr_q]              <= '0;
        end
    end

    assign bus.o_pc         = pc_q;
    assign bus.o_pop_data   = pop_data_q;
    assign bus.o_busy       = (state_q != ST_IDLE);
    assign bus.o_jump_done  = jump_done_q;
    assign bus.o_rstk_depth = depth_q;
    assign bus.o_rstk_ovf   = ovf_q;
    assign bus.o_rstk_unf   = unf_q;
    assign bus.o_dbg_val    = rstk_q[bus.i_dbg_idx];
endmodule
